// File: rtl/ba201_dmem_scratchpad.sv
// ba201_dmem_scratchpad: word-organised data scratchpad behind io_dmem.
// One request at a time, byte-masked stores, fixed access latency.
module ba201_dmem_scratchpad #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] io_dmem_addr,
  input  logic [1:0]  io_dmem_op,
  input  logic [3:0]  io_dmem_mask,
  input  logic [31:0] io_dmem_wdata,
  output logic [31:0] io_dmem_rdata,
  output logic        io_dmem_ready,
  output logic        io_dmem_err
);

  localparam int AW = $clog2(DEPTH_WORDS);

  localparam logic [32:0] LO =
    {1'b0, BASE_ADDR};
  localparam logic [32:0] HI =
    LO + (33'(DEPTH_WORDS) << 2);

  localparam logic [3:0] CNT_INIT =
    4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  state_e       state_q;
  logic [3:0]   cnt_q;
  logic [AW-1:0] idx_q;
  logic         wr_q;
  logic [3:0]   mask_q;
  logic [31:0]  wdata_q;
  logic         legal_q;
  logic [31:0]  rdata_q;
  logic         err_q;

  logic [31:0]  mem [DEPTH_WORDS];

  logic         req;
  logic         mask_ok;
  logic         range_ok;
  logic         legal_d;
  logic [AW-1:0] idx_d;
  logic [32:0]  addr_x;
  logic         commit;
  logic         commit_wr;

  assign req = (io_dmem_op == 2'd1) ||
               (io_dmem_op == 2'd2);

  assign mask_ok = io_dmem_mask inside {
    4'b0001, 4'b0010, 4'b0100, 4'b1000,
    4'b0011, 4'b1100, 4'b1111
  };

  // 33-bit compare so the window never wraps at 2^32
  assign addr_x   = {1'b0, io_dmem_addr};
  assign range_ok = (addr_x >= LO) &&
                    (addr_x < HI);
  assign legal_d  = range_ok && mask_ok;

  assign idx_d = AW'(
    (io_dmem_addr - BASE_ADDR) >> 2);

  assign commit    = (state_q == BUSY) &&
                     (cnt_q == 4'd0);
  assign commit_wr = commit && legal_q &&
                     wr_q;

  assign io_dmem_ready =
    (state_q == DONE) ||
    ((state_q == IDLE) && !req);

  assign io_dmem_rdata = rdata_q;
  assign io_dmem_err   = err_q;

  // Array write port: only the enabled byte lanes are stored
  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mask_q[i]) begin
          mem[idx_q][8*i +: 8] <=
            wdata_q[8*i +: 8];
        end
      end
    end
  end

  // Request FSM: latch, count down latency, respond for one cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      mask_q  <= 4'd0;
      wdata_q <= 32'd0;
      legal_q <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (req) begin
            idx_q   <= idx_d;
            wr_q    <= (io_dmem_op == 2'd2);
            mask_q  <= io_dmem_mask;
            wdata_q <= io_dmem_wdata;
            legal_q <= legal_d;
            cnt_q   <= CNT_INIT;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= DONE;
            if (!legal_q) begin
              rdata_q <= 32'd0;
              err_q   <= 1'b1;
            end else if (wr_q) begin
              rdata_q <= 32'd0;
            end else begin
              rdata_q <= mem[idx_q];
            end
          end
        end
        DONE: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ba201_dmem_scratchpad.sv
// tb_ba201_dmem_scratchpad: scoreboard bench, two builds (latency 1 and 4).
// Stimulus pushes expected responses; a negedge monitor pops and compares.
module tb_ba201_dmem_scratchpad;

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n [2];
  logic [31:0] addr  [2];
  logic [1:0]  op    [2];
  logic [3:0]  mask  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        err   [2];

  int checks;
  int errors;

  exp_t qa[$];
  exp_t qb[$];
  logic [31:0] ma [int];
  logic [31:0] mb [int];
  time last_resp [2];
  exp_t e_mon;

  ba201_dmem_scratchpad #(
    .BASE_ADDR(32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY(1)
  ) u_a (
    .clk(clk),
    .rst(rst_n[0]),
    .io_dmem_addr(addr[0]),
    .io_dmem_op(op[0]),
    .io_dmem_mask(mask[0]),
    .io_dmem_wdata(wdata[0]),
    .io_dmem_rdata(rdata[0]),
    .io_dmem_ready(ready[0]),
    .io_dmem_err(err[0])
  );

  ba201_dmem_scratchpad #(
    .BASE_ADDR(32'h8000_0000),
    .DEPTH_WORDS(1024),
    .LATENCY(4)
  ) u_b (
    .clk(clk),
    .rst(rst_n[1]),
    .io_dmem_addr(addr[1]),
    .io_dmem_op(op[1]),
    .io_dmem_mask(mask[1]),
    .io_dmem_wdata(wdata[1]),
    .io_dmem_rdata(rdata[1]),
    .io_dmem_ready(ready[1]),
    .io_dmem_err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  function automatic bit legal(
    input logic [31:0] a,
    input logic [3:0]  m
  );
    longint unsigned x;
    bit in_rng;
    bit mk;
    x = {32'h0, a};
    in_rng = (x >= 64'h8000_0000) &&
             (x < 64'h8000_0000 + 64'd4096);
    case (m)
      4'h1, 4'h2, 4'h4, 4'h8,
      4'h3, 4'hC, 4'hF: mk = 1'b1;
      default:          mk = 1'b0;
    endcase
    return in_rng && mk;
  endfunction

  // Reference behaviour: words in an associative array per build
  function automatic exp_t model(
    input int          d,
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [3:0]  m,
    input logic [31:0] w
  );
    exp_t e;
    int idx;
    logic [31:0] word;
    e.rd  = 32'd0;
    e.err = !legal(a, m);
    if (!e.err) begin
      idx = int'((a - 32'h8000_0000) / 4);
      word = 32'd0;
      if (d == 0 && ma.exists(idx)) word = ma[idx];
      if (d == 1 && mb.exists(idx)) word = mb[idx];
      if (o == 2'd2) begin
        for (int i = 0; i < 4; i++)
          if (m[i]) word[8*i +: 8] = w[8*i +: 8];
        if (d == 0) ma[idx] = word;
        else        mb[idx] = word;
      end else begin
        e.rd = word;
      end
    end
    return e;
  endfunction

  // Issue one request, hold it until ready, check latency
  task automatic req(
    input int          d,
    input logic [1:0]  o,
    input logic [31:0] a,
    input logic [3:0]  m,
    input logic [31:0] w
  );
    exp_t e;
    int low;
    e = model(d, o, a, m, w);
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
    op[d] = o;
    addr[d] = a;
    mask[d] = m;
    wdata[d] = w;
    low = 0;
    forever begin
      @(negedge clk);
      if (ready[d]) break;
      low++;
      if (low > 40) break;
    end
    checks++;
    if (low != lat(d) + 1) begin
      errors++;
      $display("FAIL latency dut%0d addr %h got %0d need %0d",
               d, a, low, lat(d) + 1);
    end
    last_resp[d] = $time;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d, input logic [1:0] o);
    op[d] = o;
    @(negedge clk);
    checks++;
    if (ready[d] !== 1'b1) begin
      errors++;
      $display("FAIL idle_ready dut%0d op %0d got %b need 1",
               d, o, ready[d]);
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop on each response, otherwise err must be low
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n[d]) continue;
      if (ready[d] && (op[d] == 2'd1 || op[d] == 2'd2)) begin
        checks++;
        if ((d == 0 && qa.size() == 0) ||
            (d == 1 && qb.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_resp dut%0d got rdata %h need none",
                   d, rdata[d]);
        end else begin
          e_mon = (d == 0) ? qa.pop_front() : qb.pop_front();
          if (rdata[d] !== e_mon.rd || err[d] !== e_mon.err) begin
            errors++;
            $display("FAIL resp dut%0d got %h/%b need %h/%b",
                     d, rdata[d], err[d], e_mon.rd, e_mon.err);
          end
        end
      end else begin
        checks++;
        if (err[d] !== 1'b0) begin
          errors++;
          $display("FAIL err_pulse dut%0d got %b need 0",
                   d, err[d]);
        end
      end
    end
  end

  function automatic logic [3:0] rnd_mask();
    if ($urandom_range(0, 9) < 8) begin
      case ($urandom_range(0, 6))
        0: return 4'h1;
        1: return 4'h2;
        2: return 4'h4;
        3: return 4'h8;
        4: return 4'h3;
        5: return 4'hC;
        default: return 4'hF;
      endcase
    end
    return 4'($urandom);
  endfunction

  function automatic logic [31:0] rnd_addr();
    int r;
    logic [31:0] lo2;
    r = $urandom_range(0, 9);
    lo2 = 32'($urandom_range(0, 3));
    if (r < 6)
      return 32'h8000_0000 + 32'($urandom_range(0, 7)) * 4 + lo2;
    if (r < 8)
      return 32'h8000_0000 + 32'($urandom_range(1020, 1023)) * 4 + lo2;
    case ($urandom_range(0, 3))
      0: return 32'h7FFF_FFFC;
      1: return 32'h8000_1000 + lo2;
      2: return 32'hFFFF_FFFC;
      default: return 32'h0000_0010;
    endcase
  endfunction

  initial begin
    time t1;
    checks = 0;
    errors = 0;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      op[d] = 2'd0;
      addr[d] = 32'd0;
      mask[d] = 4'd0;
      wdata[d] = 32'd0;
      last_resp[d] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;

    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rdata[d] !== 32'd0 || err[d] !== 1'b0 ||
          ready[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset dut%0d got %h/%b/%b need 0/0/1",
                 d, rdata[d], err[d], ready[d]);
      end
    end
    @(posedge clk);
    #1;

    req(0, 2'd2, 32'h8000_0010, 4'hF, 32'hDEAD_BEEF);
    req(0, 2'd1, 32'h8000_0010, 4'hF, 32'd0);
    req(0, 2'd2, 32'h8000_0010, 4'h2, 32'h0000_5500);
    req(0, 2'd1, 32'h8000_0010, 4'hF, 32'd0);
    req(0, 2'd1, 32'h8000_1000, 4'hF, 32'd0);
    req(0, 2'd2, 32'h8000_0010, 4'h5, 32'hFFFF_FFFF);
    req(0, 2'd1, 32'h8000_0010, 4'hF, 32'd0);
    req(0, 2'd2, 32'h8000_0FFC, 4'hF, 32'h1234_5678);
    req(0, 2'd1, 32'h8000_0FFC, 4'hF, 32'd0);
    req(0, 2'd1, 32'h7FFF_FFFC, 4'hF, 32'd0);
    req(0, 2'd1, 32'hFFFF_FFFC, 4'hF, 32'd0);
    idle(0, 2'd3);
    idle(0, 2'd3);
    idle(0, 2'd3);
    idle(0, 2'd0);

    req(0, 2'd1, 32'h8000_0010, 4'hF, 32'd0);
    t1 = last_resp[0];
    req(0, 2'd1, 32'h8000_0010, 4'hF, 32'd0);
    checks++;
    if (last_resp[0] - t1 != 30) begin
      errors++;
      $display("FAIL b2b dut0 got %0t need 30", last_resp[0] - t1);
    end

    for (int w = 0; w < 8; w++)
      req(0, 2'd2, 32'h8000_0000 + 32'(w) * 4, 4'hF, $urandom);
    for (int w = 1020; w < 1024; w++)
      req(0, 2'd2, 32'h8000_0000 + 32'(w) * 4, 4'hF, $urandom);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0)
        idle(0, ($urandom_range(0, 1) == 0) ? 2'd0 : 2'd3);
      req(0, ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd2,
          rnd_addr(), rnd_mask(), $urandom);
    end
    idle(0, 2'd0);

    req(1, 2'd2, 32'h8000_0000, 4'hF, 32'h1122_3344);
    req(1, 2'd1, 32'h8000_0000, 4'hF, 32'd0);
    req(1, 2'd1, 32'h8000_1000, 4'hF, 32'd0);

    op[1] = 2'd2;
    addr[1] = 32'h8000_0000;
    mask[1] = 4'hF;
    wdata[1] = 32'hAABB_CCDD;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n[1] = 1'b0;
    op[1] = 2'd0;
    @(negedge clk);
    #1;
    rst_n[1] = 1'b1;
    @(posedge clk);
    #1;
    idle(1, 2'd0);
    checks++;
    if (rdata[1] !== 32'd0) begin
      errors++;
      $display("FAIL abort_rdata dut1 got %h need 0", rdata[1]);
    end
    req(1, 2'd1, 32'h8000_0000, 4'hF, 32'd0);
    t1 = last_resp[1];
    req(1, 2'd1, 32'h8000_0000, 4'hF, 32'd0);
    checks++;
    if (last_resp[1] - t1 != 60) begin
      errors++;
      $display("FAIL b2b dut1 got %0t need 60", last_resp[1] - t1);
    end
    idle(1, 2'd3);
    idle(1, 2'd0);

    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d/%0d need 0/0",
               qa.size(), qb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
